// File: rtl/globefish_pkg.sv
// Shared constants for the globefish OLED SPI master: register map,
// STATUS bit positions and the serialiser state encoding.
package globefish_pkg;

    localparam logic [1:0] OLED_DATA   = 2'd0;
    localparam logic [1:0] OLED_STATUS = 2'd1;
    localparam logic [1:0] OLED_DIV    = 2'd2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_LVL_LSB = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } oled_state_e;

endpackage

// File: rtl/globefish_fifo.sv
// Synchronous FIFO with occupancy count. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module globefish_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // storage array; contents need no reset since level gates every read
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // pointers and occupancy count
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/globefish_oled_spi.sv
// Write-only SPI master (mode 0, MSB first) for the OLED pads, fed from a
// Wishbone-accessible TX FIFO with a programmable SCK divider.
//
// state | meaning
// IDLE  | SCK low, SDO holds last bit; pops the FIFO when it has data
// LOW   | SCK low half-period, current bit stable on SDO
// HIGH  | SCK high half-period; at its end advance bit or fetch next byte
import globefish_pkg::*;

module globefish_oled_spi #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_RST    = 1
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        spi_oled_sck_o,
    output logic        spi_oled_sdo_o,
    output logic        busy_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          access;
    logic          wr_en;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [LW-1:0] fifo_level;
    logic          ovf_set;
    logic          ovf;
    logic [7:0]    div;
    logic [31:0]   rd_data;
    logic [31:0]   status;
    logic          unused_bits;

    oled_state_e   state, state_next;
    logic [7:0]    cnt, cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic          sck;

    assign unused_bits = &{1'b0, wb_dat_i[31:8], wb_sel_i[3:1]};

    // ack is withheld for one cycle after each ack, so a held strobe is
    // served every other cycle and never counted twice
    assign access    = wb_cyc_i && wb_stb_i && !wb_ack_o;
    assign wr_en     = access && wb_we_i && wb_sel_i[0];
    assign fifo_push = wr_en && (wb_adr_i == OLED_DATA);
    assign ovf_set   = fifo_push && fifo_full && !fifo_pop;

    globefish_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wdata  (wb_dat_i[7:0]),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    assign busy_o = (state != IDLE);

    always_comb begin
        status = '0;
        status[STAT_BUSY]  = busy_o;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_OVF]   = ovf;
        status[STAT_LVL_LSB +: 4] = 4'(fifo_level);
    end

    // register read mux
    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            OLED_STATUS: rd_data = status;
            OLED_DIV:    rd_data = {24'd0, div};
            default:     rd_data = '0;
        endcase
    end

    // bus handshake, DIV register and sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            div      <= 8'(DIV_RST);
            ovf      <= 1'b0;
        end else begin
            wb_ack_o <= access;
            wb_dat_o <= (access && !wb_we_i) ? rd_data : '0;
            if (wr_en && (wb_adr_i == OLED_DIV)) begin
                div <= wb_dat_i[7:0];
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (wr_en && (wb_adr_i == OLED_STATUS) && wb_dat_i[STAT_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

    // next-state logic: divider down-count, bit sequencing and FIFO fetch
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        fifo_pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shift_next   = fifo_rdata;
                    bit_idx_next = '0;
                    cnt_next     = div;
                    state_next   = LOW;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    cnt_next   = div;
                    state_next = HIGH;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    cnt_next = div;
                    if (bit_idx != 3'd7) begin
                        shift_next   = {shift[6:0], 1'b0};
                        bit_idx_next = bit_idx + 3'd1;
                        state_next   = LOW;
                    end else if (!fifo_empty) begin
                        fifo_pop     = 1'b1;
                        shift_next   = fifo_rdata;
                        bit_idx_next = '0;
                        state_next   = LOW;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // serialiser state; SCK is registered so the pad never sees decode glitches
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            sck     <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            sck     <= (state_next == HIGH);
        end
    end

    assign spi_oled_sck_o = sck;
    assign spi_oled_sdo_o = shift[7];

endmodule

// File: tb/tb_globefish_oled_spi.sv
// Bench for globefish_oled_spi: a schedule-based model of the SPI waveform
// checked every cycle, plus hand-computed register and transfer checks.
import globefish_pkg::*;

module tb_globefish_oled_spi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc_i, stb_i, we_i;
    logic [1:0]  adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        sck, sdo, busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    globefish_oled_spi #(.FIFO_DEPTH(4), .DIV_RST(1)) dut (
        .clk_i          (clk),
        .rst_in         (rst_n),
        .wb_cyc_i       (cyc_i),
        .wb_stb_i       (stb_i),
        .wb_we_i        (we_i),
        .wb_adr_i       (adr_i),
        .wb_dat_i       (dat_i),
        .wb_sel_i       (sel_i),
        .wb_dat_o       (dat_o),
        .wb_ack_o       (ack_o),
        .spi_oled_sck_o (sck),
        .spi_oled_sdo_o (sdo),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // model: each accepted byte occupies 16*(div+1) cycles from its start
    int          s_start[$];
    int          s_div[$];
    logic [7:0]  s_byte[$];
    int          last_end = 0;
    int          cur_div  = 1;
    bit          model_en = 0;

    task automatic clear_model();
        s_start.delete();
        s_div.delete();
        s_byte.delete();
        last_end = 0;
    endtask

    function automatic void model_out(input int t, output logic e_sck,
                                      output logic e_sdo, output logic e_busy);
        e_sck  = 1'b0;
        e_sdo  = 1'b0;
        e_busy = 1'b0;
        for (int i = 0; i < s_start.size(); i++) begin
            int h;
            int len;
            int ph;
            h   = s_div[i] + 1;
            len = 16 * h;
            if (t >= s_start[i] && t < s_start[i] + len) begin
                ph     = t - s_start[i];
                e_busy = 1'b1;
                e_sck  = ((ph % (2 * h)) >= h);
                e_sdo  = s_byte[i][7 - ph / (2 * h)];
            end else if (t >= s_start[i] + len) begin
                e_sdo = s_byte[i][0];
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        logic e_sck, e_sdo, e_busy;
        if (model_en) begin
            model_out(cyc, e_sck, e_sdo, e_busy);
            checks++;
            if (sck !== e_sck || sdo !== e_sdo || busy !== e_busy) begin
                errors++;
                if (errors < 20)
                    $display("FAIL model cycle %0d: got sck=%b sdo=%b busy=%b expected sck=%b sdo=%b busy=%b",
                             cyc, sck, sdo, busy, e_sck, e_sdo, e_busy);
            end
        end
    end

    // independent pin monitor for the hand-computed expectations
    logic [15:0] cap_bits = '0;
    int          cap_pulses = 0;
    int          busy_cycles = 0;
    logic        prev_sck = 1'b0;
    always @(negedge clk) begin
        if (sck === 1'b1 && prev_sck === 1'b0) begin
            cap_bits   = {cap_bits[14:0], sdo};
            cap_pulses = cap_pulses + 1;
        end
        if (busy === 1'b1) busy_cycles = busy_cycles + 1;
        prev_sck = sck;
    end

    task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output int p);
        int st;
        @(negedge clk);
        cyc_i = 1; stb_i = 1; we_i = 1; adr_i = adr; dat_i = dat; sel_i = sel;
        @(negedge clk);
        p = cyc;
        chk("wr_ack", {31'd0, ack_o}, 32'd1);
        cyc_i = 0; stb_i = 0; we_i = 0;
        if (model_en && adr == OLED_DATA && sel[0]) begin
            st = (p + 1 > last_end) ? p + 1 : last_end;
            s_start.push_back(st);
            s_div.push_back(cur_div);
            s_byte.push_back(dat[7:0]);
            last_end = st + 16 * (cur_div + 1);
        end
    endtask

    task automatic wb_read(input logic [1:0] adr, output logic [31:0] d);
        @(negedge clk);
        cyc_i = 1; stb_i = 1; we_i = 0; adr_i = adr; sel_i = 4'hF;
        @(negedge clk);
        chk("rd_ack", {31'd0, ack_o}, 32'd1);
        d = dat_o;
        cyc_i = 0; stb_i = 0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p, p1, s;
        int          pulses0, busy0;
        logic [31:0] d;

        rst_n = 0; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = 0; dat_i = 0; sel_i = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // reset state
        chk("rst_sck",  {31'd0, sck},   32'd0);
        chk("rst_sdo",  {31'd0, sdo},   32'd0);
        chk("rst_busy", {31'd0, busy},  32'd0);
        chk("rst_ack",  {31'd0, ack_o}, 32'd0);
        chk("rst_dat",  dat_o,          32'd0);
        clear_model();
        cur_div  = 1;
        model_en = 1;
        wb_read(OLED_STATUS, d); chk("rst_status", d, 32'h04);
        wb_read(OLED_DIV, d);    chk("rst_div",    d, 32'h01);

        // DIV=0, single byte
        wb_write(OLED_DIV, 32'd0, 4'h1, p); cur_div = 0;
        wb_read(OLED_DIV, d); chk("div0_rb", d, 32'h00);
        pulses0 = cap_pulses; busy0 = busy_cycles;
        wb_write(OLED_DATA, 32'hA5, 4'h1, p);
        wait_idle(200);
        chk("a5_bits",   {24'd0, cap_bits[7:0]}, 32'hA5);
        chk("a5_pulses", cap_pulses - pulses0,    32'd8);
        chk("a5_len",    busy_cycles - busy0,     32'd16);
        chk("a5_busy",   {31'd0, busy},           32'd0);

        // DIV=3, two bytes back to back
        wb_write(OLED_DIV, 32'd3, 4'h1, p); cur_div = 3;
        pulses0 = cap_pulses; busy0 = busy_cycles;
        wb_write(OLED_DATA, 32'h81, 4'h1, p);
        wb_write(OLED_DATA, 32'h7E, 4'h1, p);
        wait_idle(400);
        chk("b2b_bits",   {16'd0, cap_bits},   32'h817E);
        chk("b2b_pulses", cap_pulses - pulses0, 32'd16);
        chk("b2b_len",    busy_cycles - busy0,  32'd128);

        // byte select gating and reserved/DATA reads
        pulses0 = cap_pulses;
        wb_write(OLED_DATA, 32'h55, 4'hE, p);
        repeat (10) @(negedge clk);
        chk("sel_pulses", cap_pulses - pulses0, 32'd0);
        wb_read(OLED_STATUS, d); chk("sel_status", d, 32'h04);
        wb_read(2'd3, d);        chk("rsvd_read",  d, 32'h00);
        wb_read(OLED_DATA, d);   chk("data_read",  d, 32'h00);

        // overflow at DIV=7, FIFO_DEPTH=4
        model_en = 0;
        wb_write(OLED_DIV, 32'd7, 4'h1, p); cur_div = 7;
        wb_write(OLED_DATA, 32'h11, 4'h1, p1);
        s = p1 + 1;
        wb_write(OLED_DATA, 32'h22, 4'h1, p);
        wb_write(OLED_DATA, 32'h33, 4'h1, p);
        wb_write(OLED_DATA, 32'h44, 4'h1, p);
        wb_write(OLED_DATA, 32'h55, 4'h1, p);
        wb_write(OLED_DATA, 32'h66, 4'h1, p);
        wb_read(OLED_STATUS, d); chk("ovf_status", d, 32'h4B);
        wb_write(OLED_STATUS, 32'h08, 4'h1, p);
        wb_read(OLED_STATUS, d); chk("ovf_clear", d, 32'h43);

        // reset during bit 3 of the first byte (SCK high, SDO=1)
        while (cyc < s + 58) @(negedge clk);
        chk("pre_rst_sck", {31'd0, sck}, 32'd1);
        chk("pre_rst_sdo", {31'd0, sdo}, 32'd1);
        rst_n = 0;
        @(negedge clk);
        chk("mid_rst_sck",  {31'd0, sck},  32'd0);
        chk("mid_rst_sdo",  {31'd0, sdo},  32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1;
        clear_model();
        cur_div  = 1;
        model_en = 1;
        wb_read(OLED_STATUS, d); chk("post_rst_status", d, 32'h04);
        wb_read(OLED_DIV, d);    chk("post_rst_div",    d, 32'h01);

        // transfer after reset at default divider
        pulses0 = cap_pulses; busy0 = busy_cycles;
        wb_write(OLED_DATA, 32'h3C, 4'h1, p);
        wait_idle(200);
        chk("post_bits",   {24'd0, cap_bits[7:0]}, 32'h3C);
        chk("post_pulses", cap_pulses - pulses0,    32'd8);
        chk("post_len",    busy_cycles - busy0,     32'd32);

        repeat (4) @(negedge clk);
        model_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/globefish_oled_spi.md
# globefish_oled_spi

Write-only SPI master that drives the OLED display pins `spi_oled_sck_o` / `spi_oled_sdo_o` of `globefish_soc`. Sits between the SoC Wishbone bus and the OLED pads; the CPU pushes bytes into a small TX FIFO and the block serialises them MSB-first in SPI mode 0 at a programmable rate. Display DC/CS are driven by GPIO, not by this block.

## Interface
- `FIFO_DEPTH`, 4, TX FIFO entries; power of two, ≥2
- `DIV_RST`, 1, reset value of the clock divider register
- `clk_i` in 1: system clock
- `rst_in` in 1: reset; one clock, reset is synchronous and active-low
- `wb_cyc_i` in 1: Wishbone cycle
- `wb_stb_i` in 1: Wishbone strobe
- `wb_we_i` in 1: write enable
- `wb_adr_i` in 2: word address (byte address [3:2])
- `wb_dat_i` in 32: write data
- `wb_sel_i` in 4: byte selects; only `wb_sel_i[0]` is honoured
- `wb_dat_o` out 32: read data
- `wb_ack_o` out 1: acknowledge
- `spi_oled_sck_o` out 1: SPI clock, idle low
- `spi_oled_sdo_o` out 1: SPI data
- `busy_o` out 1: shifting or FIFO not empty

## Operation
- Registers (word address): 0 DATA (W: push `wb_dat_i[7:0]`; R: 0); 1 STATUS (R: [0] busy, [1] full, [2] empty, [3] ovf, [7:4] level; W: writing 1 to bit 3 clears ovf); 2 DIV (R/W [7:0]); 3 reserved (R 0, W ignored).
- Writes take effect only with `wb_sel_i[0]`=1.
- DATA write while FIFO full: byte dropped, ovf set (sticky), still acked.
- SCK half-period = DIV+1 clocks; SCK period = 2·(DIV+1). DIV=0 legal (clk/2).
- Mode 0: SDO changes only while SCK low; receiver samples on SCK rising edge. 8 bits per byte, MSB first.
- FSM states:
  - IDLE: SCK=0, SDO holds last value. FIFO non-empty → pop, load shift register, SDO=bit7, bit count=0, divider=DIV → LOW.
  - LOW: divider expires → SCK=1 → HIGH.
  - HIGH: divider expires → SCK=0. If bit count<7: shift, next bit on SDO, count++ → LOW. If bit count=7: FIFO non-empty → pop and load as in IDLE (back-to-back, no gap) → LOW; else → IDLE.
- DIV changes take effect at the next divider reload; an in-flight half-period completes with the old count.
- Push and pop in the same cycle: both performed; level unchanged; a push to a full FIFO in the pop cycle is accepted.

## Timing
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, SCK=0, SDO=0, `busy_o`=0, FIFO empty, ovf=0, DIV=`DIV_RST`, FSM IDLE.
- `wb_ack_o`: one-cycle pulse the cycle after `wb_cyc_i & wb_stb_i` are sampled high; never asserted on two consecutive cycles (back-to-back strobes get ack every other cycle). `wb_dat_o` valid with ack, 0 otherwise.
- Write sampled at cycle N: FIFO updated at N+1; IDLE pop at N+1; SDO=bit7 and busy at N+2; first SCK rise at N+2+DIV+1.
- Byte duration in steady stream: exactly 16·(DIV+1) clocks.
- `busy_o` falls in the same cycle the FSM enters IDLE with FIFO empty.
- Reset mid-byte: outputs return to reset values in the next cycle; FIFO content discarded; no partial SCK pulse completed.

## Structure
- Package `globefish_pkg`: register word-address constants (`OLED_DATA`, `OLED_STATUS`, `OLED_DIV`), STATUS bit indices, FSM state enum `oled_state_e` {IDLE, LOW, HIGH}.
- Sub-module `globefish_fifo` (synchronous FIFO, parameter WIDTH/DEPTH; push/pop/full/empty/level); reusable by the UART.
- Top: Wishbone register file, divider counter, FSM + 8-bit shift register.

## Test plan
- Reset, then read STATUS → 0x04 (empty), DIV reads `DIV_RST`=1; SCK=SDO=0.
- DIV=0, write 0xA5 → SDO sequence 1,0,1,0,0,1,0,1 at rising edges; 8 SCK pulses, 16 clocks; busy low afterwards.
- DIV=3, write 0x81, 0x7E back-to-back → 16 SCK pulses, no gap between bytes, total 128 clocks from first SDO valid.
- DIV=7 (slow), write 6 bytes with FIFO_DEPTH=4 → first 5 accepted (one popped), 6th dropped, STATUS ovf=1, full=1; write 0x08 to STATUS → ovf=0.
- Write with `wb_sel_i`=0xE → no push, still acked; read reserved address → 0.
- Assert `rst_in` low mid-byte at bit 3 → next cycle SCK=0, SDO=0, busy=0, STATUS=0x04.
